// File: rtl/divider_restoring_if.sv
// Operand/result bundle for the restoring divider.
// The requester drives A, B and start; the divider returns result, overflow_flag and finish.
interface divider_restoring_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             overflow_flag;
  logic             finish;

  modport master (
    output A, B, start,
    input  result, overflow_flag, finish
  );

  modport slave (
    input  A, B, start,
    output result, overflow_flag, finish
  );
endinterface

// File: rtl/divider_restoring.sv
// Sequential signed fixed-point divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, then sign fix-up and saturation to the Q format.
module divider_restoring #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  divider_restoring_if.slave  bus
);

  localparam int DW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(DW + 1);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t           state;
  logic [DW-1:0]    dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic             sign;
  logic             divzero;
  logic [WIDTH-1:0] result_r;
  logic             overflow_r;
  logic             finish_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic             sat_pos;
  logic             sat_neg;
  logic [WIDTH-1:0] final_result;
  logic             final_ovf;

  // Two's-complement negation of the most negative value yields 2^(WIDTH-1) as unsigned.
  assign abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

  // The stored remainder is always below |B| <= 2^(WIDTH-1), so WIDTH bits hold it;
  // only the shifted working value needs the extra bit.
  assign rem_shift = {rem, dividend[DW-1]};
  assign fits      = rem_shift >= {1'b0, divisor};
  assign diff      = rem_shift[WIDTH-1:0] - divisor;

  assign sat_pos = |dividend[DW-1:WIDTH-1];
  assign sat_neg = (|dividend[DW-1:WIDTH]) | (dividend[WIDTH-1] & (|dividend[WIDTH-2:0]));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    final_result = '0;
    final_ovf    = 1'b0;
    if (divzero) begin
      final_result = sign ? MIN_NEG : MAX_POS;
      final_ovf    = 1'b1;
    end else if (!sign && sat_pos) begin
      final_result = MAX_POS;
      final_ovf    = 1'b1;
    end else if (sign && sat_neg) begin
      final_result = MIN_NEG;
      final_ovf    = 1'b1;
    end else begin
      final_result = sign ? -dividend[WIDTH-1:0] : dividend[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dividend   <= '0;
      divisor    <= '0;
      rem        <= '0;
      count      <= '0;
      sign       <= 1'b0;
      divzero    <= 1'b0;
      result_r   <= '0;
      overflow_r <= 1'b0;
      finish_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finish_r <= 1'b0;
          if (bus.start) begin
            dividend <= {abs_a, {FRAC_BITS{1'b0}}};
            divisor  <= abs_b;
            sign     <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            divzero  <= (bus.B == '0);
            rem      <= '0;
            count    <= CW'(DW);
            state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (count != '0) begin
            rem      <= fits ? diff : rem_shift[WIDTH-1:0];
            dividend <= {dividend[DW-2:0], fits};
            count    <= count - CW'(1);
          end else begin
            result_r   <= final_result;
            overflow_r <= final_ovf;
            finish_r   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (!bus.start) begin
            finish_r <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result        = result_r;
  assign bus.overflow_flag = overflow_r;
  assign bus.finish        = finish_r;

endmodule

// File: tb/tb_divider_restoring.sv
// Directed bench for divider_restoring: the driver queues hand-computed results,
// a monitor pops and compares them on each rising edge of finish.
module tb_divider_restoring;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 27;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             ovf;
    int               start_cycle;
  } exp_t;

  logic clk;
  logic rst;
  int   cycle;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_finish;

  divider_restoring_if #(.WIDTH(WIDTH)) dif ();

  divider_restoring #(.WIDTH(WIDTH), .FRAC_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every new finish pulse must match the oldest queued expectation.
  initial prev_finish = 1'b0;
  always @(negedge clk) begin
    if (dif.finish === 1'b1 && prev_finish !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: got result 0x%0h with no pending operation", dif.result);
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'(dif.result), 32'(mon_e.result));
        check("overflow", 32'(dif.overflow_flag), 32'(mon_e.ovf));
        check("latency", cycle - mon_e.start_cycle, LATENCY);
      end
    end
    prev_finish = dif.finish;
  end

  // Issues one operation from a negedge, waits for finish, holds start, then drops it.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_r, input logic exp_o,
                        input int hold, input bit disturb);
    exp_t e;
    int   n;
    dif.A     = a;
    dif.B     = b;
    dif.start = 1'b1;
    e.result      = exp_r;
    e.ovf         = exp_o;
    e.start_cycle = cycle + 1;
    sb.push_back(e);
    if (disturb) begin
      repeat (5) @(negedge clk);
      dif.A     = 16'h1234;
      dif.B     = 16'h0000;
      dif.start = 1'b0;
      repeat (3) @(negedge clk);
      dif.A     = 16'h8000;
      dif.B     = 16'hFFFF;
      dif.start = 1'b1;
    end
    n = 0;
    while (dif.finish !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (dif.finish !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL finish_timeout: finish=%b after %0d cycles, required 1", dif.finish, n);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_finish", 32'(dif.finish), 32'd1);
      check("hold_result", 32'(dif.result), 32'(exp_r));
      check("hold_overflow", 32'(dif.overflow_flag), 32'(exp_o));
    end
    dif.start = 1'b0;
    @(negedge clk);
    check("finish_drop", 32'(dif.finish), 32'd0);
    check("result_retained", 32'(dif.result), 32'(exp_r));
  endtask

  logic [WIDTH-1:0] vec_a  [9] = '{16'h0C00, 16'hF400, 16'h0001, 16'hFFFF, 16'h7FFF,
                                   16'h8000, 16'hE000, 16'hF000, 16'h0400};
  logic [WIDTH-1:0] vec_b  [9] = '{16'h0800, 16'h0800, 16'h0003, 16'h0C00, 16'h0001,
                                   16'h0001, 16'h0100, 16'h0000, 16'h0000};
  logic [WIDTH-1:0] vec_r  [9] = '{16'h0600, 16'hFA00, 16'h0155, 16'h0000, 16'h7FFF,
                                   16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
  logic             vec_o  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    dif.A     = '0;
    dif.B     = '0;
    dif.start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", 32'(dif.result), 32'd0);
    check("reset_overflow", 32'(dif.overflow_flag), 32'd0);
    check("reset_finish", 32'(dif.finish), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back directed vectors, one start-low edge between them.
    for (int i = 0; i < 9; i++)
      run_op(vec_a[i], vec_b[i], vec_r[i], vec_o[i], 0, 1'b0);

    // Operand/start disturbance during DIVIDE, then start held in DONE.
    run_op(16'h0C00, 16'h0800, 16'h0600, 1'b0, 10, 1'b1);

    // Reset in the middle of a divide aborts it with no output.
    dif.A     = 16'h7000;
    dif.B     = 16'h0300;
    dif.start = 1'b1;
    repeat (10) @(negedge clk);
    rst       = 1'b1;
    dif.start = 1'b0;
    @(negedge clk);
    check("midreset_finish", 32'(dif.finish), 32'd0);
    check("midreset_result", 32'(dif.result), 32'd0);
    check("midreset_overflow", 32'(dif.overflow_flag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'h0400, 16'h0400, 16'h0400, 1'b0, 0, 1'b0);

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
